// File: rtl/zxuno_regbus_ctrl.sv
// -----------------------------------------------------------------------------
// zxuno_regbus_ctrl
// Front-end controller for the ZX-UNO internal register space.
// Decodes Z80 I/O cycles to the register-address port and register-data port,
// holds the current register address, and generates one strobe per CPU
// access for the register peripherals. Read data from up to NSRC peripherals
// is arbitrated (lowest enabled index wins) onto the single CPU read bus.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cpu_a/cpu_din      CPU address bus / write data
//   iorq_n,m1_n,rd_n,wr_n  Z80 bus control (active-low)
//   src_dout/src_oe_n  packed peripheral read data / per-source enables
//   zxuno_addr         current register address
//   zxuno_regrd        level while a register-data read is in progress
//   zxuno_regwr        one-cycle register-data write pulse
//   zxuno_dout         write data captured with zxuno_regwr
//   regaddr_changed    one-cycle pulse after each address-port write
//   cpu_dout/cpu_oe_n  registered CPU read data / drive enable
//   bus_conflict       sticky flag: multiple sources enabled during a read
// -----------------------------------------------------------------------------
module zxuno_regbus_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] ADDR_PORT = 16'hFC3B,
    parameter logic [15:0] DATA_PORT = 16'hFD3B,
    parameter logic [7:0]  INIT_ADDR = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         cpu_a,
    input  logic [7:0]          cpu_din,
    input  logic                iorq_n,
    input  logic                m1_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [8*NSRC-1:0]   src_dout,
    input  logic [NSRC-1:0]     src_oe_n,
    output logic [7:0]          zxuno_addr,
    output logic                zxuno_regrd,
    output logic                zxuno_regwr,
    output logic [7:0]          zxuno_dout,
    output logic                regaddr_changed,
    output logic [7:0]          cpu_dout,
    output logic                cpu_oe_n,
    output logic                bus_conflict
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AWR  = 3'd1,
        ST_ARD  = 3'd2,
        ST_DWR  = 3'd3,
        ST_DRD  = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    state_t      state_r;
    state_t      next_s;

    logic        acc_rd_s;
    logic        acc_wr_s;
    logic        hit_a_s;
    logic        hit_d_s;

    logic [7:0]  arb_dout_s;
    logic        arb_oe_n_s;
    logic        arb_multi_s;

    // Reads keep driving only while the access is still present; an enable
    // that shows up on the cycle the read ends is therefore not captured.
    logic        keep_ard_s;
    logic        keep_drd_s;

    logic [7:0]  zxuno_addr_r;
    logic        zxuno_regrd_r;
    logic        zxuno_regwr_r;
    logic [7:0]  zxuno_dout_r;
    logic        regaddr_changed_r;
    logic [7:0]  cpu_dout_r;
    logic        cpu_oe_n_r;
    logic        bus_conflict_r;

    assign acc_rd_s   = !iorq_n && m1_n && !rd_n && wr_n;
    assign acc_wr_s   = !iorq_n && m1_n && !wr_n && rd_n;
    assign hit_a_s    = (cpu_a == ADDR_PORT);
    assign hit_d_s    = (cpu_a == DATA_PORT);
    assign keep_ard_s = (state_r == ST_ARD) && (next_s == ST_ARD);
    assign keep_drd_s = (state_r == ST_DRD) && (next_s == ST_DRD);

    // Read-source arbiter: lowest enabled index wins, extra enables flag a conflict.
    always_comb begin
        arb_dout_s  = 8'hFF;
        arb_oe_n_s  = 1'b1;
        arb_multi_s = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (!src_oe_n[i] && arb_oe_n_s) begin
                arb_dout_s = src_dout[8*i +: 8];
                arb_oe_n_s = 1'b0;
            end else if (!src_oe_n[i]) begin
                arb_multi_s = 1'b1;
            end else begin
                arb_multi_s = arb_multi_s;
            end
        end
    end

    // Next-state logic; HOLD absorbs the remainder of every access.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_wr_s && hit_a_s) begin
                    next_s = ST_AWR;
                end else if (acc_rd_s && hit_a_s) begin
                    next_s = ST_ARD;
                end else if (acc_wr_s && hit_d_s) begin
                    next_s = ST_DWR;
                end else if (acc_rd_s && hit_d_s) begin
                    next_s = ST_DRD;
                end else if (acc_rd_s || acc_wr_s) begin
                    next_s = ST_HOLD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_AWR:  next_s = ST_HOLD;
            ST_DWR:  next_s = ST_HOLD;
            ST_ARD: begin
                if (acc_rd_s && hit_a_s) begin
                    next_s = ST_ARD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_DRD: begin
                if (acc_rd_s && hit_d_s) begin
                    next_s = ST_DRD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (acc_rd_s || acc_wr_s) begin
                    next_s = ST_HOLD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            default: next_s = ST_HOLD;
        endcase
    end

    // State register; reset parks in HOLD so an in-flight access is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= next_s;
        end
    end

    // Registered strobes, captured address/data and CPU read bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zxuno_addr_r      <= INIT_ADDR;
            zxuno_regrd_r     <= 1'b0;
            zxuno_regwr_r     <= 1'b0;
            zxuno_dout_r      <= 8'h00;
            regaddr_changed_r <= 1'b0;
            cpu_dout_r        <= 8'hFF;
            cpu_oe_n_r        <= 1'b1;
            bus_conflict_r    <= 1'b0;
        end else begin
            regaddr_changed_r <= (next_s == ST_AWR);
            zxuno_regwr_r     <= (next_s == ST_DWR);
            zxuno_regrd_r     <= (next_s == ST_DRD);
            if (next_s == ST_AWR) begin
                zxuno_addr_r <= cpu_din;
            end
            if (next_s == ST_DWR) begin
                zxuno_dout_r <= cpu_din;
            end
            if (keep_ard_s) begin
                cpu_dout_r <= zxuno_addr_r;
                cpu_oe_n_r <= 1'b0;
            end else if (keep_drd_s) begin
                cpu_dout_r <= arb_dout_s;
                cpu_oe_n_r <= arb_oe_n_s;
            end else begin
                cpu_dout_r <= 8'hFF;
                cpu_oe_n_r <= 1'b1;
            end
            if (next_s == ST_AWR) begin
                bus_conflict_r <= 1'b0;
            end else if (keep_drd_s && arb_multi_s) begin
                bus_conflict_r <= 1'b1;
            end
        end
    end

    assign zxuno_addr      = zxuno_addr_r;
    assign zxuno_regrd     = zxuno_regrd_r;
    assign zxuno_regwr     = zxuno_regwr_r;
    assign zxuno_dout      = zxuno_dout_r;
    assign regaddr_changed = regaddr_changed_r;
    assign cpu_dout        = cpu_dout_r;
    assign cpu_oe_n        = cpu_oe_n_r;
    assign bus_conflict    = bus_conflict_r;

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zxuno_regbus_ctrl
// Scoreboard bench: each stimulus step queues the values the outputs must
// show at a given cycle; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_zxuno_regbus_ctrl;

    localparam int NSRC = 8;

    localparam int SIG_ADDR  = 0;
    localparam int SIG_REGRD = 1;
    localparam int SIG_REGWR = 2;
    localparam int SIG_DOUT  = 3;
    localparam int SIG_CHG   = 4;
    localparam int SIG_CDOUT = 5;
    localparam int SIG_OEN   = 6;
    localparam int SIG_CONF  = 7;

    typedef struct {
        int          at_cyc;
        int          sig;
        logic [31:0] exp;
        string       tag;
    } sb_item_t;

    logic                clk;
    logic                rst_n;
    logic [15:0]         cpu_a;
    logic [7:0]          cpu_din;
    logic                iorq_n;
    logic                m1_n;
    logic                rd_n;
    logic                wr_n;
    logic [8*NSRC-1:0]   src_dout;
    logic [NSRC-1:0]     src_oe_n;
    logic [7:0]          zxuno_addr;
    logic                zxuno_regrd;
    logic                zxuno_regwr;
    logic [7:0]          zxuno_dout;
    logic                regaddr_changed;
    logic [7:0]          cpu_dout;
    logic                cpu_oe_n;
    logic                bus_conflict;

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    sb_item_t sb_q[$];

    zxuno_regbus_ctrl #(.NSRC(NSRC)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_din(cpu_din),
        .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
        .src_dout(src_dout), .src_oe_n(src_oe_n),
        .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr), .zxuno_dout(zxuno_dout),
        .regaddr_changed(regaddr_changed), .cpu_dout(cpu_dout),
        .cpu_oe_n(cpu_oe_n), .bus_conflict(bus_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_sig(input int sig);
        case (sig)
            SIG_ADDR:  return {24'd0, zxuno_addr};
            SIG_REGRD: return {31'd0, zxuno_regrd};
            SIG_REGWR: return {31'd0, zxuno_regwr};
            SIG_DOUT:  return {24'd0, zxuno_dout};
            SIG_CHG:   return {31'd0, regaddr_changed};
            SIG_CDOUT: return {24'd0, cpu_dout};
            SIG_OEN:   return {31'd0, cpu_oe_n};
            SIG_CONF:  return {31'd0, bus_conflict};
            default:   return 32'hDEAD;
        endcase
    endfunction

    // Compare every queued expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at_cyc == cyc) begin
                chk_val(sb_q[i].tag, get_sig(sb_q[i].sig), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    end

    task automatic exp_at(input int off, input int sig, input logic [31:0] val, input string name);
        sb_item_t it;
        it.at_cyc = cyc + off;
        it.sig    = sig;
        it.exp    = val;
        it.tag    = $sformatf("%s@c%0d", name, cyc + off);
        sb_q.push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [7:0] d, input logic en);
        src_dout[8*idx +: 8] = d;
        src_oe_n[idx]        = !en;
    endtask

    task automatic exp_reset_vals(input int off);
        exp_at(off, SIG_ADDR,  32'h00, "rst_addr");
        exp_at(off, SIG_REGRD, 32'h0,  "rst_regrd");
        exp_at(off, SIG_REGWR, 32'h0,  "rst_regwr");
        exp_at(off, SIG_DOUT,  32'h00, "rst_dout");
        exp_at(off, SIG_CHG,   32'h0,  "rst_chg");
        exp_at(off, SIG_CDOUT, 32'hFF, "rst_cdout");
        exp_at(off, SIG_OEN,   32'h1,  "rst_oen");
        exp_at(off, SIG_CONF,  32'h0,  "rst_conf");
    endtask

    task automatic io_write(input logic [15:0] port, input logic [7:0] d, input int len);
        cpu_a = port; cpu_din = d; iorq_n = 1'b0; wr_n = 1'b0;
        tick(len);
        iorq_n = 1'b1; wr_n = 1'b1;
        tick(2);
    endtask

    task automatic io_read(input logic [15:0] port, input int len);
        cpu_a = port; iorq_n = 1'b0; rd_n = 1'b0;
        tick(len);
        iorq_n = 1'b1; rd_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpu_a = 16'h0000; cpu_din = 8'h00;
        iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        src_dout = '0; src_oe_n = '1;
        tick(3);
        exp_reset_vals(0);
        rst_n = 1'b1;
        tick(2);

        // Address write FFh, held 4 cycles
        exp_at(0, SIG_CHG, 32'h0, "awr_chg");
        exp_at(1, SIG_CHG, 32'h1, "awr_chg");
        exp_at(2, SIG_CHG, 32'h0, "awr_chg");
        exp_at(1, SIG_ADDR, 32'hFF, "awr_addr");
        exp_at(4, SIG_ADDR, 32'hFF, "awr_addr");
        for (int i = 0; i <= 5; i++) exp_at(i, SIG_REGWR, 32'h0, "awr_regwr");
        io_write(16'hFC3B, 8'hFF, 4);

        // Data write 5Ah held 6 cycles, then a second write
        exp_at(0, SIG_REGWR, 32'h0, "dwr_regwr");
        exp_at(1, SIG_REGWR, 32'h1, "dwr_regwr");
        for (int i = 2; i <= 6; i++) exp_at(i, SIG_REGWR, 32'h0, "dwr_regwr");
        exp_at(1, SIG_DOUT, 32'h5A, "dwr_dout");
        exp_at(6, SIG_DOUT, 32'h5A, "dwr_dout");
        io_write(16'hFD3B, 8'h5A, 6);
        exp_at(1, SIG_REGWR, 32'h1, "dwr2_regwr");
        exp_at(2, SIG_REGWR, 32'h0, "dwr2_regwr");
        exp_at(1, SIG_DOUT, 32'hA5, "dwr2_dout");
        exp_at(1, SIG_CHG, 32'h0, "dwr2_chg");
        io_write(16'hFD3B, 8'hA5, 3);

        // Data read from source 3, 5 cycles
        set_src(3, 8'h54, 1'b1);
        exp_at(0, SIG_REGRD, 32'h0, "drd_regrd");
        for (int i = 1; i <= 5; i++) exp_at(i, SIG_REGRD, 32'h1, "drd_regrd");
        exp_at(6, SIG_REGRD, 32'h0, "drd_regrd");
        exp_at(1, SIG_OEN, 32'h1, "drd_oen");
        for (int i = 2; i <= 5; i++) exp_at(i, SIG_OEN, 32'h0, "drd_oen");
        exp_at(6, SIG_OEN, 32'h1, "drd_oen");
        exp_at(2, SIG_CDOUT, 32'h54, "drd_cdout");
        exp_at(5, SIG_CDOUT, 32'h54, "drd_cdout");
        exp_at(6, SIG_CDOUT, 32'hFF, "drd_cdout");
        io_read(16'hFD3B, 5);
        set_src(3, 8'h00, 1'b0);

        // Two sources together: lowest index wins, conflict sticky
        set_src(1, 8'hA1, 1'b1);
        set_src(4, 8'hB4, 1'b1);
        exp_at(1, SIG_CONF, 32'h0, "conf_flag");
        exp_at(2, SIG_CONF, 32'h1, "conf_flag");
        exp_at(2, SIG_CDOUT, 32'hA1, "conf_cdout");
        exp_at(2, SIG_OEN, 32'h0, "conf_oen");
        io_read(16'hFD3B, 3);
        set_src(1, 8'h00, 1'b0);
        set_src(4, 8'h00, 1'b0);
        tick(2);
        exp_at(0, SIG_CONF, 32'h1, "conf_sticky");
        exp_at(1, SIG_CONF, 32'h0, "conf_clr");
        exp_at(1, SIG_ADDR, 32'h3C, "awr2_addr");
        exp_at(1, SIG_CHG, 32'h1, "awr2_chg");
        io_write(16'hFC3B, 8'h3C, 2);

        // Address read-back
        exp_at(1, SIG_CDOUT, 32'hFF, "ard_cdout");
        exp_at(2, SIG_CDOUT, 32'h3C, "ard_cdout");
        exp_at(3, SIG_CDOUT, 32'h3C, "ard_cdout");
        exp_at(4, SIG_CDOUT, 32'hFF, "ard_cdout");
        exp_at(1, SIG_OEN, 32'h1, "ard_oen");
        exp_at(2, SIG_OEN, 32'h0, "ard_oen");
        exp_at(4, SIG_OEN, 32'h1, "ard_oen");
        io_read(16'hFC3B, 3);

        // Foreign port and interrupt acknowledge: no strobes, bus not driven
        set_src(2, 8'h77, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            exp_at(i, SIG_OEN, 32'h1, "fe_oen");
            exp_at(i, SIG_REGRD, 32'h0, "fe_regrd");
        end
        io_read(16'h00FE, 3);
        m1_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_at(i, SIG_OEN, 32'h1, "ack_oen");
            exp_at(i, SIG_REGRD, 32'h0, "ack_regrd");
        end
        io_read(16'hFD3B, 3);
        exp_at(1, SIG_CHG, 32'h0, "ackw_chg");
        exp_at(2, SIG_ADDR, 32'h3C, "ackw_addr");
        io_write(16'hFC3B, 8'h99, 2);
        m1_n = 1'b1;
        set_src(2, 8'h00, 1'b0);
        tick(1);

        // Reset in the middle of a data read with iorq_n still low
        set_src(3, 8'h54, 1'b1);
        set_src(5, 8'hC5, 1'b1);
        exp_at(1, SIG_REGRD, 32'h1, "mid_regrd");
        exp_at(3, SIG_OEN, 32'h0, "mid_oen");
        exp_at(3, SIG_CDOUT, 32'h54, "mid_cdout");
        exp_at(3, SIG_CONF, 32'h1, "mid_conf");
        cpu_a = 16'hFD3B; iorq_n = 1'b0; rd_n = 1'b0;
        tick(3);
        exp_reset_vals(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_at(i, SIG_REGRD, 32'h0, "post_regrd");
            exp_at(i, SIG_OEN, 32'h1, "post_oen");
        end
        tick(3);
        iorq_n = 1'b1; rd_n = 1'b1;
        exp_at(1, SIG_REGRD, 32'h0, "rel_regrd");
        tick(2);
        exp_at(1, SIG_REGRD, 32'h1, "fresh_regrd");
        exp_at(2, SIG_CDOUT, 32'h54, "fresh_cdout");
        io_read(16'hFD3B, 2);
        set_src(3, 8'h00, 1'b0);
        set_src(5, 8'h00, 1'b0);

        tick(3);
        chk_val("sb_drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zxuno_regbus_ctrl.md
Name: zxuno_regbus_ctrl

Overview:
Front-end controller for the ZX-UNO internal register space. Decodes CPU I/O accesses to the register-address port and register-data port, and holds the current register address. Generates the read/write strobes and the address-change pulse consumed by register peripherals, such as the core-ID text streamer at address FFh. Arbitrates the read-data returns of up to NSRC peripherals onto the single CPU read bus.

Parameters:
NSRC, 8, number of peripheral read sources (1..16)
ADDR_PORT, 16'hFC3B, full 16-bit I/O port that selects the register address
DATA_PORT, 16'hFD3B, full 16-bit I/O port for register data
INIT_ADDR, 8'h00, zxuno_addr value after reset

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cpu_a  in  16  CPU address bus
cpu_din  in  8  CPU write data
iorq_n  in  1  Z80 IORQ, active-low
m1_n  in  1  Z80 M1, active-low; low together with iorq_n means interrupt acknowledge, which is ignored
rd_n  in  1  Z80 RD, active-low
wr_n  in  1  Z80 WR, active-low
src_dout  in  8*NSRC  packed peripheral read data; source i at bits [8i+7:8i]
src_oe_n  in  NSRC  per-source output enable, active-low
zxuno_addr  out  8  current register address (registered)
zxuno_regrd  out  1  level: register-data read in progress
zxuno_regwr  out  1  one-cycle pulse: register-data write
zxuno_dout  out  8  write data captured for zxuno_regwr
regaddr_changed  out  1  one-cycle pulse after any write to ADDR_PORT
cpu_dout  out  8  read data to CPU (registered)
cpu_oe_n  out  1  CPU read-bus drive enable, active-low (registered)
bus_conflict  out  1  sticky: two or more sources enabled together

Behaviour:
- acc_rd = !iorq_n & m1_n & !rd_n & wr_n; acc_wr = !iorq_n & m1_n & !wr_n & rd_n. If rd_n and wr_n are both low, no access is recognised.
- hit_a = (cpu_a == ADDR_PORT); hit_d = (cpu_a == DATA_PORT). Decoding uses all 16 address bits.
- FSM states: IDLE, AWR, ARD, DWR, DRD, HOLD. Transitions are evaluated at each posedge clk.
- IDLE: on acc_wr & hit_a go to AWR; acc_rd & hit_a go to ARD; acc_wr & hit_d go to DWR; acc_rd & hit_d go to DRD. Any other access goes to HOLD.
- AWR (exactly 1 cycle):
  - zxuno_addr <= cpu_din sampled on the IDLE->AWR edge.
  - regaddr_changed = 1 during this cycle. It pulses even when the new value equals the old one.
  - bus_conflict is cleared.
  - Next state HOLD.
- DWR (exactly 1 cycle): zxuno_regwr = 1 and zxuno_dout = cpu_din sampled on entry; next state HOLD.
- ARD: cpu_oe_n = 0 and cpu_dout = zxuno_addr, from the cycle after entry. Stays in ARD while acc_rd & hit_a, otherwise goes to IDLE.
- DRD:
  - zxuno_regrd = 1 for every cycle in DRD.
  - Each cycle, cpu_dout/cpu_oe_n are registered from the arbiter, so they show 1-cycle latency versus src_oe_n.
  - Stays in DRD while acc_rd & hit_d, otherwise goes to IDLE. zxuno_regrd therefore drops on the first cycle after the access ends; peripherals advance internal pointers on that falling edge.
- HOLD: waits until neither acc_rd nor acc_wr is active, then goes to IDLE. This guarantees one strobe per CPU access, whatever the access length.
- Arbiter (combinational, used in DRD):
  - The lowest-index source with src_oe_n[i] = 0 wins.
  - If no source is enabled, the output is data FFh with oe_n = 1, so the CPU bus floats.
  - If two or more are enabled in any DRD cycle, bus_conflict <= 1. It stays set until reset or the next AWR.
- Outside ARD/DRD: cpu_oe_n = 1, cpu_dout = FFh, registered.
- Reset (rst_n = 0 at posedge):
  - zxuno_addr = INIT_ADDR, zxuno_dout = 00h, cpu_dout = FFh.
  - zxuno_regrd, zxuno_regwr, regaddr_changed and bus_conflict = 0; cpu_oe_n = 1.
  - FSM goes to HOLD, so an access already in flight when reset releases is ignored until iorq_n goes high.
- Simultaneous events:
  - An address change and a data read cannot overlap, because the FSM serialises them.
  - A source enable arriving in the same cycle the read ends is ignored.

Test Plan:
- Reset, then OUT FC3B,FFh (wr held 4 cycles) -> zxuno_addr = FFh one cycle later; regaddr_changed high exactly 1 cycle; zxuno_regwr never asserted.
- OUT FD3B,5Ah held 6 cycles -> zxuno_regwr high exactly 1 cycle with zxuno_dout = 5Ah; a second OUT after iorq_n release -> second single pulse.
- Source 3 holds src_oe_n low with dout 54h during IN FD3B (5 cycles) -> zxuno_regrd high for 5 cycles and low the cycle after release; cpu_dout = 54h with cpu_oe_n = 0 from cycle 2 of the read.
- Sources 1 (A1h) and 4 (B4h) enabled together during a data read -> cpu_dout = A1h; bus_conflict = 1 and stays set; next OUT FC3B clears it.
- IN FC3B after setting address 3Ch -> cpu_dout = 3Ch; IN 00FEh and an interrupt acknowledge (iorq_n & m1_n both low) -> no strobes, cpu_oe_n stays 1.
- rst_n pulsed low mid IN FD3B with iorq_n still low -> all outputs at reset values, zxuno_addr = INIT_ADDR; no zxuno_regrd until the CPU starts a fresh access after iorq_n goes high.
